mem_fill_writer: RTL and testbench

- Write-side companion to the team's 8-entry read-only memory path. It accepts a byte stream over a valid/ready handshake and writes it into an internal 8x8 memory. Writes start at a programmed base address, auto-increment and wrap.
- It also provides the synchronous read port (clk, rd, add, data_out) that the existing read benches drive, so a filled image can be read back unchanged.

---
 rtl/mem_fill_writer_pkg.sv | 31 +++
 rtl/mem_fill_writer_ram_8x8.sv | 47 ++++
 rtl/mem_fill_writer.sv | 98 +++++++++
 tb/tb_mem_fill_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared constants, FSM state encoding and length saturation for
//            the memory fill writer.
// Revision : 1.0
// ============================================================================
package mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A burst can never usefully write more words than the memory holds.
    function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
        logic [ADDR_W:0] c_depth_l;
        c_depth_l = (ADDR_W + 1)'(DEPTH);
        if (len > c_depth_l) begin
            return c_depth_l;
        end
        return len;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_fill_writer_ram_8x8.sv
`default_nettype none
// ============================================================================
// Module   : ram_8x8
// Brief    : Small synchronous RAM, one write port and one registered read
//            port, cleared on reset, read-before-write on address collision.
// Revision : 1.0
// ============================================================================
module ram_8x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Both ports sample the array before this edge's write takes effect,
    // so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_rd) begin
                r_rd_data <= r_mem[i_rd_addr];
            end
            if (i_we) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : ram_8x8
`default_nettype wire

// File: rtl/mem_fill_writer.sv
`default_nettype none
// ============================================================================
// Module   : mem_fill_writer
// Brief    : Streams a valid/ready byte burst into an 8x8 RAM from a base
//            address with wrapping auto-increment; exposes a registered read.
// Revision : 1.0
// ============================================================================
module mem_fill_writer
    import mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    input  logic              rd,
    input  logic [ADDR_W-1:0] add,
    output logic [DATA_W-1:0] data_out
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_err;
    logic              w_xfer;

    assign in_ready = (r_state == WRITE);
    assign busy     = (r_state == WRITE);
    assign done     = (r_state == DONE);
    assign err      = r_err;
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_remaining <= '0;
            r_err       <= 1'b0;
        end else begin
            // A start that arrives mid-burst is dropped but remembered.
            if (start && (r_state != IDLE)) begin
                r_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wr_ptr    <= base_addr;
                        r_remaining <= sat_len(len);
                        r_state     <= (len == '0) ? DONE : WRITE;
                    end
                end
                WRITE: begin
                    if (w_xfer) begin
                        r_wr_ptr    <= r_wr_ptr + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == (ADDR_W + 1)'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ram_8x8 #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_xfer),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (in_data),
        .i_rd      (rd),
        .i_rd_addr (add),
        .o_rd_data (data_out)
    );

endmodule : mem_fill_writer
`default_nettype wire

// File: tb/tb_mem_fill_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_fill_writer
// Brief    : Directed self-checking bench for mem_fill_writer.
// Revision : 1.0
// ============================================================================
module tb_mem_fill_writer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] base_addr;
    logic [3:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       rd;
    logic [2:0] add;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    mem_fill_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rd        (rd),
        .add       (add),
        .data_out  (data_out)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] pat     [16];
    logic [7:0] exp_mem [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic read_word(input logic [2:0] a, output logic [7:0] v);
        rd  = 1'b1;
        add = a;
        tick();
        rd  = 1'b0;
        v   = data_out;
    endtask

    task automatic check_mem(input string tag);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
            read_word(i[2:0], v);
            check_eq($sformatf("%s_mem%0d", tag, i), {24'd0, v}, {24'd0, exp_mem[i]});
        end
    endtask

    // Drives one burst from pat[]; gap idle cycles follow each accepted word.
    // inj_at >= 0 raises a second start once that many words are accepted.
    task automatic burst(input logic [2:0] b, input logic [3:0] l, input int gap,
                         input int inj_at, input logic [2:0] inj_base,
                         output int cycles, output int writes, output bit stall_ok);
        int idx      = 0;
        int gapc     = 0;
        int edges    = 0;
        bit inj_done = 1'b0;
        start     = 1'b1;
        base_addr = b;
        len       = l;
        in_valid  = 1'b0;
        tick();
        start    = 1'b0;
        edges    = 1;
        writes   = 0;
        stall_ok = 1'b1;
        while (done !== 1'b1 && edges < 100) begin
            if (gapc > 0) begin
                in_valid = 1'b0;
                gapc--;
            end else begin
                in_valid = 1'b1;
                in_data  = pat[idx];
            end
            if (!inj_done && inj_at >= 0 && writes == inj_at) begin
                start     = 1'b1;
                base_addr = inj_base;
                len       = 4'd2;
                inj_done  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (in_ready !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            if (in_valid && in_ready) begin
                writes++;
                idx++;
                gapc = gap;
            end
            tick();
            edges++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        cycles   = edges + 1;
        if (edges >= 100) check_eq("burst_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int         cyc;
        int         wr;
        bit         sok;
        logic [7:0] v;

        rst = 1'b0; start = 1'b0; base_addr = '0; len = '0;
        in_valid = 1'b0; in_data = '0; rd = 1'b0; add = '0;

        // Reset state
        do_reset();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_busy",     {31'd0, busy},     32'd0);
        check_eq("rst_done",     {31'd0, done},     32'd0);
        check_eq("rst_err",      {31'd0, err},      32'd0);
        check_eq("rst_data_out", {24'd0, data_out}, 32'd0);

        // Full fill base 0, len 8, data 0x10..0x17
        for (int i = 0; i < 16; i++) pat[i] = 8'h10 + 8'(i);
        burst(3'd0, 4'd8, 0, -1, 3'd0, cyc, wr, sok);
        check_eq("full_cycles",    cyc, 32'd10);
        check_eq("full_writes",    wr,  32'd8);
        check_eq("full_done_rdy",  {31'd0, in_ready}, 32'd0);
        check_eq("full_done_busy", {31'd0, busy},     32'd0);
        tick();
        check_eq("full_done_once", {31'd0, done}, 32'd0);
        check_eq("full_err",       {31'd0, err},  32'd0);
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h10 + 8'(i);
        check_mem("full");
        tick();
        check_eq("read_hold", {24'd0, data_out}, 32'h17);

        // Wrap-around base 6, len 4
        do_reset();
        pat[0] = 8'hA1; pat[1] = 8'hA2; pat[2] = 8'hA3; pat[3] = 8'hA4;
        burst(3'd6, 4'd4, 0, -1, 3'd0, cyc, wr, sok);
        check_eq("wrap_cycles", cyc, 32'd6);
        tick();
        exp_mem = '{8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2};
        check_mem("wrap");

        // Same-address read and write in one cycle returns the old word
        start = 1'b1; base_addr = 3'd6; len = 4'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'h5A; rd = 1'b1; add = 3'd6;
        tick();
        in_valid = 1'b0; rd = 1'b0;
        check_eq("rbw_old_word", {24'd0, data_out}, 32'hA1);
        check_eq("rbw_done",     {31'd0, done},     32'd1);
        tick();
        read_word(3'd6, v);
        check_eq("rbw_new_word", {24'd0, v}, 32'h5A);

        // Stall: base 2, len 3, three idle cycles between words
        do_reset();
        pat[0] = 8'h55; pat[1] = 8'h66; pat[2] = 8'h77;
        burst(3'd2, 4'd3, 3, -1, 3'd0, cyc, wr, sok);
        check_eq("stall_ready_busy", {31'd0, sok}, 32'd1);
        check_eq("stall_writes",     wr,  32'd3);
        check_eq("stall_cycles",     cyc, 32'd11);
        tick();
        check_eq("stall_done_once", {31'd0, done}, 32'd0);
        exp_mem = '{8'h00, 8'h00, 8'h55, 8'h66, 8'h77, 8'h00, 8'h00, 8'h00};
        check_mem("stall");

        // len 0: done two cycles after start, memory untouched
        burst(3'd5, 4'd0, 0, -1, 3'd0, cyc, wr, sok);
        check_eq("len0_cycles", cyc, 32'd2);
        check_eq("len0_writes", wr,  32'd0);
        tick();
        check_mem("len0");

        // len 12 saturates to 8
        do_reset();
        for (int i = 0; i < 16; i++) pat[i] = 8'hC0 + 8'(i);
        burst(3'd0, 4'd12, 0, -1, 3'd0, cyc, wr, sok);
        check_eq("sat_writes", wr,  32'd8);
        check_eq("sat_cycles", cyc, 32'd10);
        tick();
        check_eq("sat_idle_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'hC0 + 8'(i);
        check_mem("sat");

        // start mid-burst is ignored and flags err
        do_reset();
        pat[0] = 8'h31; pat[1] = 8'h32; pat[2] = 8'h33; pat[3] = 8'h34;
        burst(3'd1, 4'd4, 0, 2, 3'd5, cyc, wr, sok);
        check_eq("inj_cycles", cyc, 32'd6);
        check_eq("inj_writes", wr,  32'd4);
        check_eq("inj_err",    {31'd0, err}, 32'd1);
        tick(); tick(); tick();
        check_eq("inj_err_sticky", {31'd0, err},  32'd1);
        check_eq("inj_idle_busy",  {31'd0, busy}, 32'd0);
        exp_mem = '{8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'h00, 8'h00, 8'h00};
        check_mem("inj");

        // Reset after 2 of 5 writes
        start = 1'b1; base_addr = 3'd0; len = 4'd5;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 8'hE0;
        tick();
        in_data = 8'hE1;
        tick();
        rst = 1'b1; in_data = 8'hE2;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("mid_rst_busy",  {31'd0, busy},     32'd0);
        check_eq("mid_rst_err",   {31'd0, err},      32'd0);
        check_eq("mid_rst_dout",  {24'd0, data_out}, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) exp_mem[i] = 8'h00;
        check_mem("mid_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_fill_writer
`default_nettype wire
